sprite_motion_ctrl: RTL and testbench
=====================================

// Module: sprite_motion_ctrl
// PURPOSE
//  Frame-synchronous motion scheduler for one rectangular sprite on the 1024x768 display path.
//  Detects frame start from the timing counters and, once every FRAMES_PER_MOVE frames, computes the
//  next top-left position with edge bounce. Commits it during vertical blanking so the pixel stage never tears.
//  Time-shares one axis-step unit between X and Y. Feeds pos_x/pos_y to the pixel/colour stage.
// PARAMETERS
//  H_ACTIVE      1024  visible pixels per line
//  V_ACTIVE      768   visible lines per frame
//  SPR_W         128   sprite width in pixels
//  SPR_H         96    sprite height in lines
//  DIV_W         8     width of frames-per-move divider
// PORTS
//  clk              in   1      pixel clock (65 MHz)
//  rst_n            in   1      asynchronous reset, active-low
//  h_counter        in   12     raw horizontal timing counter
//  v_counter        in   12     raw vertical timing counter; wraps to 0 at frame start
//  enable           in   1      1 = motion runs; 0 = position frozen, divider held
//  frames_per_move  in   DIV_W  move once per N frames; 0 treated as 1
//  step_x, step_y   in   4      pixels per move per axis (0 = axis stationary)
//  cfg_load         in   1      one-cycle strobe: load init_* immediately
//  init_x, init_y   in   12     start position (active-area coords); clamped to max on load
//  init_hdir,init_vdir in 1     start direction (0 = +x / +y, 1 = -x / -y)
//  pos_x, pos_y     out  12     committed sprite top-left, active-area coords
//  hdir, vdir       out  1      current direction bits
//  bounce_x,bounce_y out 1      one-cycle pulse on the COMMIT that reversed that axis
//  upd_done         out  1      one-cycle pulse when a new position is committed
//  busy             out  1      high in any state other than IDLE
// BEHAVIOUR
//  Reset: pos_x=pos_y=0, hdir=vdir=0, bounce_*=0, upd_done=0, busy=0, divider=0, state=IDLE.
//  Frame event: v_counter sampled each cycle; event = (v_counter==0) && (previous sample != 0).
//    This fires exactly once per frame, on the first cycle of line 0.
//  FSM IDLE -> DIV -> CALC_X -> CALC_Y -> COMMIT -> IDLE, one cycle per state:
//    IDLE: on frame event with enable=1, go to DIV.
//    DIV: if divider+1 >= max(frames_per_move,1), clear divider and go to CALC_X.
//         Otherwise increment divider and go to IDLE.
//    CALC_X: the shared step unit computes nx, nhdir and flip_x from pos_x, hdir, step_x and XMAX=H_ACTIVE-SPR_W.
//    CALC_Y: the same unit computes ny, nvdir and flip_y from pos_y, vdir, step_y and YMAX=V_ACTIVE-SPR_H.
//    COMMIT: pos_x/pos_y/hdir/vdir <= working values; bounce_x=flip_x, bounce_y=flip_y, upd_done=1 (pulses).
//  Latency: event sampled in cycle T -> outputs change at the end of cycle T+4 (well inside vblank).
//  Step arithmetic, 13-bit unsigned, no wrap:
//    dir=0: sum=p+step; if sum>=MAX then p'=MAX, dir'=1, flip=(step!=0); else p'=sum.
//    dir=1: if p<=step then p'=0, dir'=0, flip=(step!=0); else p'=p-step.
//    step=0: position is unchanged and no flip occurs, even when sitting on a boundary.
//  cfg_load has priority in every state:
//    Next cycle, pos/dir take init values (clamped to MAX), working regs take the same values.
//    State goes to IDLE, divider clears, no pulses.
//  enable=0 mid-update: the sequence in flight completes; later events are ignored.
//  Frame event while busy: dropped (unreachable at legal timings).
//  step_* and frames_per_move are sampled in CALC_X/CALC_Y/DIV respectively.
//    Changes take effect on the next sequence.
//  Reset asserted mid-sequence: all state returns to reset values asynchronously.
// STRUCTURE
//  Shared include vga_params.vh: H_ACTIVE, V_ACTIVE, blanking widths, state encodings (IDLE..COMMIT).
//  One sub-module: sprite_axis_step (combinational; in p,dir,step,max -> out p',dir',flip).
//    It is muxed between the X and Y operands by state.
// TESTING
//  T1 reset: rst_n low mid-frame -> all outputs 0, busy 0; release, 1 frame, step 1/1 -> pos (1,1), upd_done 1 pulse.
//  T2 latency: FPM=1, v_counter 805->0 at cycle T -> pos updates at T+4.
//     busy high T+1..T+4; exactly one upd_done per frame.
//  T3 right/bottom bounce: init (890,670), dirs 0, step 8/4 -> pos (896,672).
//     hdir=vdir=1, bounce_x=bounce_y=1; next move -> (888,668).
//  T4 left/top bounce: init (3,2), dirs 1, step 5/5 -> pos (0,0), dirs 0, both bounce pulses.
//     step_x=0 at x=0 -> no flip, no pulse.
//  T5 divider/enable: FPM=3 -> one update per 3 frames over 9 frames (3 updates).
//     enable=0 for 2 frames -> pos frozen, divider unchanged.
//  T6 cfg_load during CALC_Y -> no COMMIT occurs; pos=(init_x,init_y) next cycle.
//     init_x=2000 -> pos_x=896.

Source files
------------

// File: rtl/sprite_motion_ctrl_pkg.sv
// Shared constants, FSM encoding and small helpers for the sprite motion scheduler.
// Sprite bounds are derived from the 1024x768 active area and the sprite size.
package sprite_motion_ctrl_pkg;

  localparam int H_ACTIVE = 1024;
  localparam int V_ACTIVE = 768;
  localparam int H_BLANK  = 320;
  localparam int V_BLANK  = 38;
  localparam int SPR_W    = 128;
  localparam int SPR_H    = 96;
  localparam int DIV_W    = 8;
  localparam int POS_W    = 12;
  localparam int STEP_W   = 4;

  localparam logic [POS_W-1:0] XMAX = POS_W'(H_ACTIVE - SPR_W);
  localparam logic [POS_W-1:0] YMAX = POS_W'(V_ACTIVE - SPR_H);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DIV    = 3'd1,
    ST_CALC_X = 3'd2,
    ST_CALC_Y = 3'd3,
    ST_COMMIT = 3'd4
  } state_t;

  function automatic logic [POS_W-1:0] clamp_pos(input logic [POS_W-1:0] p,
                                                 input logic [POS_W-1:0] max);
    if (p > max) begin
      clamp_pos = max;
    end else begin
      clamp_pos = p;
    end
  endfunction

endpackage

// File: rtl/sprite_axis_step.sv
// One-axis move with edge bounce, shared between X and Y by the scheduler.
// Purely combinational; 13-bit sum so position + step can never wrap.
module sprite_axis_step
  import sprite_motion_ctrl_pkg::*;
(
  input  logic [POS_W-1:0]  p,
  input  logic              dir,
  input  logic [STEP_W-1:0] step,
  input  logic [POS_W-1:0]  max,
  output logic [POS_W-1:0]  p_next,
  output logic              dir_next,
  output logic              flip
);

  logic [POS_W:0] sum_s;
  logic [POS_W:0] step_ext_s;

  assign step_ext_s = {{(POS_W+1-STEP_W){1'b0}}, step};
  assign sum_s      = {1'b0, p} + step_ext_s;

  // Bounce rule: a zero step leaves the axis untouched even on a boundary.
  always_comb begin
    p_next   = p;
    dir_next = dir;
    flip     = 1'b0;
    if (step == {STEP_W{1'b0}}) begin
      p_next   = p;
      dir_next = dir;
      flip     = 1'b0;
    end else if (dir == 1'b0) begin
      if (sum_s >= {1'b0, max}) begin
        p_next   = max;
        dir_next = 1'b1;
        flip     = 1'b1;
      end else begin
        p_next   = sum_s[POS_W-1:0];
        dir_next = dir;
        flip     = 1'b0;
      end
    end else begin
      if ({1'b0, p} <= step_ext_s) begin
        p_next   = {POS_W{1'b0}};
        dir_next = 1'b0;
        flip     = 1'b1;
      end else begin
        p_next   = p - step_ext_s[POS_W-1:0];
        dir_next = dir;
        flip     = 1'b0;
      end
    end
  end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Frame-synchronous sprite position scheduler: divides frames, steps X then Y
// through one shared step unit, and commits the new position inside vblank.
module sprite_motion_ctrl
  import sprite_motion_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [11:0]       h_counter,
  input  logic [11:0]       v_counter,
  input  logic              enable,
  input  logic [DIV_W-1:0]  frames_per_move,
  input  logic [STEP_W-1:0] step_x,
  input  logic [STEP_W-1:0] step_y,
  input  logic              cfg_load,
  input  logic [POS_W-1:0]  init_x,
  input  logic [POS_W-1:0]  init_y,
  input  logic              init_hdir,
  input  logic              init_vdir,
  output logic [POS_W-1:0]  pos_x,
  output logic [POS_W-1:0]  pos_y,
  output logic              hdir,
  output logic              vdir,
  output logic              bounce_x,
  output logic              bounce_y,
  output logic              upd_done,
  output logic              busy
);

  state_t state_r, state_next_s;

  logic [11:0]       v_prev_r;
  logic [DIV_W-1:0]  div_r;
  logic [POS_W-1:0]  pos_x_r, pos_y_r, work_x_r, work_y_r;
  logic              hdir_r, vdir_r, work_hdir_r, work_vdir_r;
  logic              flip_x_r, flip_y_r;
  logic              bounce_x_r, bounce_y_r, upd_done_r, busy_r;

  logic              frame_evt_s;
  logic [DIV_W-1:0]  fpm_eff_s;
  logic              div_wrap_s;
  logic [POS_W-1:0]  op_p_s, op_max_s, sp_p_s;
  logic [STEP_W-1:0] op_step_s;
  logic              op_dir_s, sp_dir_s, sp_flip_s;
  logic              unused_h_s;

  // The frame event is defined on line 0 alone, so the horizontal counter is not consulted.
  assign unused_h_s  = ^h_counter;
  assign frame_evt_s = (v_counter == 12'd0) && (v_prev_r != 12'd0);
  assign fpm_eff_s   = (frames_per_move == {DIV_W{1'b0}}) ? {{(DIV_W-1){1'b0}}, 1'b1}
                                                          : frames_per_move;
  assign div_wrap_s  = ({1'b0, div_r} + {{DIV_W{1'b0}}, 1'b1}) >= {1'b0, fpm_eff_s};

  // Previous vertical count for frame-start edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_prev_r <= 12'd0;
    end else begin
      v_prev_r <= v_counter;
    end
  end

  // Next-state logic; a configuration load aborts any sequence in flight.
  always_comb begin
    state_next_s = state_r;
    if (cfg_load) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:   state_next_s = (frame_evt_s && enable) ? ST_DIV : ST_IDLE;
        ST_DIV:    state_next_s = div_wrap_s ? ST_CALC_X : ST_IDLE;
        ST_CALC_X: state_next_s = ST_CALC_Y;
        ST_CALC_Y: state_next_s = ST_COMMIT;
        ST_COMMIT: state_next_s = ST_IDLE;
        default:   state_next_s = ST_IDLE;
      endcase
    end
  end

  // State register and registered busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != ST_IDLE);
    end
  end

  // Operand mux for the shared step unit.
  always_comb begin
    case (state_r)
      ST_CALC_Y: begin
        op_p_s    = pos_y_r;
        op_dir_s  = vdir_r;
        op_step_s = step_y;
        op_max_s  = YMAX;
      end
      default: begin
        op_p_s    = pos_x_r;
        op_dir_s  = hdir_r;
        op_step_s = step_x;
        op_max_s  = XMAX;
      end
    endcase
  end

  sprite_axis_step u_axis_step (
    .p        (op_p_s),
    .dir      (op_dir_s),
    .step     (op_step_s),
    .max      (op_max_s),
    .p_next   (sp_p_s),
    .dir_next (sp_dir_s),
    .flip     (sp_flip_s)
  );

  // Divider, working registers, committed position and update pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r       <= {DIV_W{1'b0}};
      pos_x_r     <= {POS_W{1'b0}};
      pos_y_r     <= {POS_W{1'b0}};
      hdir_r      <= 1'b0;
      vdir_r      <= 1'b0;
      work_x_r    <= {POS_W{1'b0}};
      work_y_r    <= {POS_W{1'b0}};
      work_hdir_r <= 1'b0;
      work_vdir_r <= 1'b0;
      flip_x_r    <= 1'b0;
      flip_y_r    <= 1'b0;
      bounce_x_r  <= 1'b0;
      bounce_y_r  <= 1'b0;
      upd_done_r  <= 1'b0;
    end else if (cfg_load) begin
      div_r       <= {DIV_W{1'b0}};
      pos_x_r     <= clamp_pos(init_x, XMAX);
      pos_y_r     <= clamp_pos(init_y, YMAX);
      hdir_r      <= init_hdir;
      vdir_r      <= init_vdir;
      work_x_r    <= clamp_pos(init_x, XMAX);
      work_y_r    <= clamp_pos(init_y, YMAX);
      work_hdir_r <= init_hdir;
      work_vdir_r <= init_vdir;
      flip_x_r    <= 1'b0;
      flip_y_r    <= 1'b0;
      bounce_x_r  <= 1'b0;
      bounce_y_r  <= 1'b0;
      upd_done_r  <= 1'b0;
    end else begin
      bounce_x_r <= 1'b0;
      bounce_y_r <= 1'b0;
      upd_done_r <= 1'b0;
      case (state_r)
        ST_DIV: begin
          if (div_wrap_s) begin
            div_r <= {DIV_W{1'b0}};
          end else begin
            div_r <= div_r + {{(DIV_W-1){1'b0}}, 1'b1};
          end
        end
        ST_CALC_X: begin
          work_x_r    <= sp_p_s;
          work_hdir_r <= sp_dir_s;
          flip_x_r    <= sp_flip_s;
        end
        ST_CALC_Y: begin
          work_y_r    <= sp_p_s;
          work_vdir_r <= sp_dir_s;
          flip_y_r    <= sp_flip_s;
        end
        ST_COMMIT: begin
          pos_x_r    <= work_x_r;
          pos_y_r    <= work_y_r;
          hdir_r     <= work_hdir_r;
          vdir_r     <= work_vdir_r;
          bounce_x_r <= flip_x_r;
          bounce_y_r <= flip_y_r;
          upd_done_r <= 1'b1;
        end
        default: begin
          div_r <= div_r;
        end
      endcase
    end
  end

  assign pos_x    = pos_x_r;
  assign pos_y    = pos_y_r;
  assign hdir     = hdir_r;
  assign vdir     = vdir_r;
  assign bounce_x = bounce_x_r;
  assign bounce_y = bounce_y_r;
  assign upd_done = upd_done_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Self-checking bench for sprite_motion_ctrl: a frame-level schedule model checked
// every cycle, plus hand-computed positions for bounce, divider and load cases.
module tb_sprite_motion_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] h_counter, v_counter;
  logic        enable;
  logic [7:0]  frames_per_move;
  logic [3:0]  step_x, step_y;
  logic        cfg_load;
  logic [11:0] init_x, init_y;
  logic        init_hdir, init_vdir;
  logic [11:0] pos_x, pos_y;
  logic        hdir, vdir, bounce_x, bounce_y, upd_done, busy;

  int tests = 0;
  int fails = 0;
  int upd_cnt = 0;
  logic last_bx = 1'b0, last_by = 1'b0;

  // Model state: position, direction, pulses, remaining busy cycles, frame divider.
  int m_x, m_y, m_hd, m_vd, m_left, m_div, m_prev;
  bit m_bx, m_by, m_upd, m_moving;

  always #5 clk = ~clk;

  sprite_motion_ctrl dut (
    .clk(clk), .rst_n(rst_n), .h_counter(h_counter), .v_counter(v_counter),
    .enable(enable), .frames_per_move(frames_per_move), .step_x(step_x), .step_y(step_y),
    .cfg_load(cfg_load), .init_x(init_x), .init_y(init_y), .init_hdir(init_hdir),
    .init_vdir(init_vdir), .pos_x(pos_x), .pos_y(pos_y), .hdir(hdir), .vdir(vdir),
    .bounce_x(bounce_x), .bounce_y(bounce_y), .upd_done(upd_done), .busy(busy)
  );

  function automatic void mv(input int p, input int d, input int s, input int mx,
                             output int np, output int nd, output bit fl);
    np = p; nd = d; fl = 1'b0;
    if (s != 0) begin
      if (d == 0) begin
        if (p + s >= mx) begin np = mx; nd = 1; fl = 1'b1; end
        else np = p + s;
      end else begin
        if (p <= s) begin np = 0; nd = 0; fl = 1'b1; end
        else np = p - s;
      end
    end
  endfunction

  task automatic model_reset();
    m_x = 0; m_y = 0; m_hd = 0; m_vd = 0; m_left = 0; m_div = 0; m_prev = 0;
    m_bx = 1'b0; m_by = 1'b0; m_upd = 1'b0; m_moving = 1'b0;
  endtask

  task automatic model_step();
    bit evt;
    int eff, np, nd;
    bit fl;
    if (!rst_n) begin
      model_reset();
    end else begin
      evt = (v_counter == 12'd0) && (m_prev != 0);
      m_prev = int'(v_counter);
      m_bx = 1'b0; m_by = 1'b0; m_upd = 1'b0;
      if (cfg_load) begin
        m_x = (init_x > 12'd896) ? 896 : int'(init_x);
        m_y = (init_y > 12'd672) ? 672 : int'(init_y);
        m_hd = int'(init_hdir); m_vd = int'(init_vdir);
        m_left = 0; m_div = 0;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0 && m_moving) begin
          mv(m_x, m_hd, int'(step_x), 896, np, nd, fl); m_x = np; m_hd = nd; m_bx = fl;
          mv(m_y, m_vd, int'(step_y), 672, np, nd, fl); m_y = np; m_vd = nd; m_by = fl;
          m_upd = 1'b1;
        end
      end else if (evt && enable) begin
        eff = (frames_per_move == 8'd0) ? 1 : int'(frames_per_move);
        if (m_div + 1 >= eff) begin m_div = 0; m_moving = 1'b1; m_left = 4; end
        else begin m_div++; m_moving = 1'b0; m_left = 1; end
      end
    end
  endtask

  task automatic compare();
    tests++;
    if (pos_x !== 12'(m_x) || pos_y !== 12'(m_y) || hdir !== m_hd[0] || vdir !== m_vd[0] ||
        bounce_x !== m_bx || bounce_y !== m_by || upd_done !== m_upd || busy !== (m_left > 0)) begin
      fails++;
      $display("FAIL cycle_model t=%0t dut pos=(%0d,%0d) dir=%b%b bnc=%b%b upd=%b busy=%b | want pos=(%0d,%0d) dir=%0d%0d bnc=%b%b upd=%b busy=%b",
               $time, pos_x, pos_y, hdir, vdir, bounce_x, bounce_y, upd_done, busy,
               m_x, m_y, m_hd, m_vd, m_bx, m_by, m_upd, (m_left > 0));
    end
    if (upd_done === 1'b1) begin
      upd_cnt++;
      last_bx = bounce_x;
      last_by = bounce_y;
    end
  endtask

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // One clock: compare on the falling edge, advance the model on the rising edge.
  task automatic cyc();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_step();
    #1;
    h_counter = h_counter + 12'd1;
  endtask

  task automatic frame();
    v_counter = 12'd805; repeat (4) cyc();
    v_counter = 12'd0;   repeat (8) cyc();
    v_counter = 12'd1;   repeat (4) cyc();
  endtask

  task automatic load(input int x, input int y, input bit hd, input bit vd);
    init_x = 12'(x); init_y = 12'(y); init_hdir = hd; init_vdir = vd;
    cfg_load = 1'b1; cyc();
    cfg_load = 1'b0;
  endtask

  initial begin
    int c0;
    rst_n = 1'b0; h_counter = 12'd0; v_counter = 12'd1; enable = 1'b0;
    frames_per_move = 8'd1; step_x = 4'd0; step_y = 4'd0; cfg_load = 1'b0;
    init_x = 12'd0; init_y = 12'd0; init_hdir = 1'b0; init_vdir = 1'b0;
    model_reset();
    repeat (3) cyc();
    check("reset_pos_x", pos_x, 0);
    check("reset_busy", busy, 0);
    rst_n = 1'b1;

    // T1: first move from reset, then reset mid-sequence
    enable = 1'b1; step_x = 4'd1; step_y = 4'd1;
    frame();
    check("t1_pos_x", pos_x, 1);
    check("t1_pos_y", pos_y, 1);
    check("t1_upd_cnt", upd_cnt, 1);
    v_counter = 12'd805; repeat (2) cyc();
    v_counter = 12'd0;   repeat (2) cyc();
    check("t1_busy_mid", busy, 1);
    rst_n = 1'b0; model_reset();
    #1;
    check("t1_rst_pos_x", pos_x, 0);
    check("t1_rst_pos_y", pos_y, 0);
    check("t1_rst_busy", busy, 0);
    check("t1_rst_upd", upd_done, 0);
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (4) cyc();
    v_counter = 12'd1; repeat (4) cyc();

    // T2: event-to-commit latency
    load(100, 100, 1'b0, 1'b0);
    v_counter = 12'd805; repeat (3) cyc();
    v_counter = 12'd0;
    check("t2_busy_T", busy, 0);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      check("t2_busy_Tk", busy, 1);
      check("t2_hold_x", pos_x, 100);
    end
    cyc();
    check("t2_pos_x_T5", pos_x, 101);
    check("t2_upd_T5", upd_done, 1);
    check("t2_busy_T5", busy, 0);
    repeat (4) cyc();
    v_counter = 12'd1; repeat (4) cyc();

    // T3: right/bottom bounce
    load(890, 670, 1'b0, 1'b0);
    step_x = 4'd8; step_y = 4'd4;
    frame();
    check("t3_pos_x", pos_x, 896);
    check("t3_pos_y", pos_y, 672);
    check("t3_hdir", hdir, 1);
    check("t3_vdir", vdir, 1);
    check("t3_bounce_x", last_bx, 1);
    check("t3_bounce_y", last_by, 1);
    frame();
    check("t3_pos_x2", pos_x, 888);
    check("t3_pos_y2", pos_y, 668);
    check("t3_bounce_x2", last_bx, 0);

    // T4: left/top bounce, then a stationary axis on the edge
    load(3, 2, 1'b1, 1'b1);
    step_x = 4'd5; step_y = 4'd5;
    frame();
    check("t4_pos_x", pos_x, 0);
    check("t4_pos_y", pos_y, 0);
    check("t4_hdir", hdir, 0);
    check("t4_bounce_x", last_bx, 1);
    check("t4_bounce_y", last_by, 1);
    step_x = 4'd0;
    frame();
    check("t4_still_x", pos_x, 0);
    check("t4_pos_y2", pos_y, 5);
    check("t4_no_bounce_x", last_bx, 0);

    // T5: divider and enable
    load(10, 10, 1'b0, 1'b0);
    step_x = 4'd1; step_y = 4'd1; frames_per_move = 8'd3;
    c0 = upd_cnt;
    repeat (9) frame();
    check("t5_upd_9frames", upd_cnt - c0, 3);
    check("t5_pos_x", pos_x, 13);
    frame();
    enable = 1'b0;
    repeat (2) frame();
    check("t5_frozen_x", pos_x, 13);
    check("t5_frozen_cnt", upd_cnt - c0, 3);
    enable = 1'b1;
    frame();
    check("t5_div_kept", pos_x, 13);
    frame();
    check("t5_resume_x", pos_x, 14);
    frames_per_move = 8'd1;

    // T6: load during CALC_Y aborts the commit
    v_counter = 12'd805; repeat (3) cyc();
    v_counter = 12'd0;
    repeat (3) cyc();
    c0 = upd_cnt;
    init_x = 12'd2000; init_y = 12'd500; init_hdir = 1'b0; init_vdir = 1'b0;
    cfg_load = 1'b1; cyc();
    cfg_load = 1'b0;
    check("t6_pos_x", pos_x, 896);
    check("t6_pos_y", pos_y, 500);
    check("t6_busy", busy, 0);
    repeat (6) cyc();
    check("t6_no_commit", upd_cnt - c0, 0);
    v_counter = 12'd1; repeat (4) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
